// File: rtl/sap_pkg.sv
// Shared definitions for the SAP sequencer: opcodes, FSM states, default widths.
package sap_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_LDA  = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OP_W-1:0] OP_BUN  = 4'h5;
  localparam logic [OP_W-1:0] OP_CALL = 4'h6;
  localparam logic [OP_W-1:0] OP_RET  = 4'h7;
  localparam logic [OP_W-1:0] OP_OUT  = 4'h8;
  localparam logic [OP_W-1:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    S_ADDR,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  // LDA/ADD/SUB need the extra memory-operand cycle.
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/sap_sequencer_if.sv
// ROM, run control and datapath strobe bundle between the sequencer and its neighbours.
interface sap_sequencer_if #(
  parameter int unsigned ADDR_W = sap_pkg::ADDR_W
);
  logic              run;
  logic [7:0]        rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_low_oe;
  logic              acc_load;
  logic              alu_en;
  logic              alu_sub;
  logic              out_load;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              fault;

  modport master (
    input  run, rom_data,
    output rom_addr, rom_low_oe, acc_load, alu_en, alu_sub, out_load, pc, halted, fault
  );

  modport slave (
    output run, rom_data,
    input  rom_addr, rom_low_oe, acc_load, alu_en, alu_sub, out_load, pc, halted, fault
  );
endinterface

// File: rtl/sap_ret_stack.sv
// Return-address LIFO for CALL/RET; push/pop are ignored when full/empty.
module sap_ret_stack #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              clr_low,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top_c,
  output logic              full_c,
  output logic              empty_c
);
  localparam int unsigned SP_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [SP_W-1:0]   sp;

  assign full_c  = (sp == SP_W'(DEPTH));
  assign empty_c = (sp == '0);
  assign top_c   = mem[IDX_W'(sp - SP_W'(1))];

  // Stack pointer: counts valid entries.
  always_ff @(posedge clk or negedge clr_low) begin
    if (!clr_low) begin
      sp <= '0;
    end else if (push && !full_c) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty_c) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Entry storage; contents above sp are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (push && !full_c) begin
      mem[IDX_W'(sp)] <= din;
    end
  end

endmodule

// File: rtl/sap_sequencer.sv
// SAP-style instruction sequencer: fetch/decode/execute FSM, PC, IR and
// optional return stack. Optional feature macro: SAP_CALL_STACK_EN
// (defined: CALL/RET use a STACK_DEPTH-entry return stack; undefined:
// opcodes 0x6/0x7 are illegal and fault the sequencer).
module sap_sequencer #(
  parameter int unsigned ADDR_W      = sap_pkg::ADDR_W,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            clr_low,
  sap_sequencer_if.master bus
);
  import sap_pkg::*;

  if (STACK_DEPTH < 1 || STACK_DEPTH > 8) begin : g_depth_check
    $error("sap_sequencer: STACK_DEPTH must be 1..8");
  end

  state_t            state;
  logic [7:0]        ir;
  logic [ADDR_W-1:0] pc;

  logic [OP_W-1:0]   opcode_c;
  logic [ADDR_W-1:0] operand_c;
  logic [ADDR_W-1:0] pc_inc_c;

  assign opcode_c  = ir[7:4];
  assign operand_c = ADDR_W'(ir[3:0]);
  assign pc_inc_c  = pc + ADDR_W'(1);
  assign bus.pc    = pc;

`ifdef SAP_CALL_STACK_EN
  logic              push_c;
  logic              pop_c;
  logic [ADDR_W-1:0] stk_top_c;
  logic              stk_full_c;
  logic              stk_empty_c;

  assign push_c = (state == S_EXEC) && (opcode_c == OP_CALL);
  assign pop_c  = (state == S_EXEC) && (opcode_c == OP_RET);

  sap_ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_ret_stack (
    .clk     (clk),
    .clr_low (clr_low),
    .push    (push_c),
    .pop     (pop_c),
    .din     (pc),
    .top_c   (stk_top_c),
    .full_c  (stk_full_c),
    .empty_c (stk_empty_c)
  );
`endif

  // Sequencer FSM; outputs are registered with the value of the state being entered.
  always_ff @(posedge clk or negedge clr_low) begin
    if (!clr_low) begin
      state          <= S_ADDR;
      pc             <= '0;
      ir             <= '0;
      bus.rom_addr   <= '0;
      bus.rom_low_oe <= 1'b1;
      bus.acc_load   <= 1'b0;
      bus.alu_en     <= 1'b0;
      bus.alu_sub    <= 1'b0;
      bus.out_load   <= 1'b0;
      bus.halted     <= 1'b0;
      bus.fault      <= 1'b0;
    end else begin
      bus.rom_low_oe <= 1'b1;
      bus.acc_load   <= 1'b0;
      bus.alu_en     <= 1'b0;
      bus.alu_sub    <= 1'b0;
      bus.out_load   <= 1'b0;
      case (state)
        S_ADDR: begin
          bus.rom_addr <= pc;
          if (bus.run) begin
            state          <= S_FETCH;
            bus.rom_low_oe <= 1'b0;
          end
        end
        S_FETCH: begin
          ir           <= bus.rom_data;
          pc           <= pc_inc_c;
          bus.rom_addr <= pc_inc_c;
          bus.out_load <= (bus.rom_data[7:4] == OP_OUT);
          state        <= S_EXEC;
        end
        S_EXEC: begin
          state        <= S_ADDR;
          bus.rom_addr <= pc;
          if (is_mem_op(opcode_c)) begin
            state          <= S_MEM;
            bus.rom_addr   <= operand_c;
            bus.rom_low_oe <= 1'b0;
            bus.acc_load   <= 1'b1;
            bus.alu_en     <= (opcode_c != OP_LDA);
            bus.alu_sub    <= (opcode_c == OP_SUB);
          end else begin
            case (opcode_c)
              OP_BUN: begin
                pc           <= operand_c;
                bus.rom_addr <= operand_c;
              end
`ifdef SAP_CALL_STACK_EN
              OP_CALL: begin
                if (stk_full_c) begin
                  state      <= S_HALT;
                  bus.halted <= 1'b1;
                  bus.fault  <= 1'b1;
                end else begin
                  pc           <= operand_c;
                  bus.rom_addr <= operand_c;
                end
              end
              OP_RET: begin
                if (stk_empty_c) begin
                  state      <= S_HALT;
                  bus.halted <= 1'b1;
                  bus.fault  <= 1'b1;
                end else begin
                  pc           <= stk_top_c;
                  bus.rom_addr <= stk_top_c;
                end
              end
`else
              OP_CALL, OP_RET: begin
                state      <= S_HALT;
                bus.halted <= 1'b1;
                bus.fault  <= 1'b1;
              end
`endif
              OP_HLT: begin
                state      <= S_HALT;
                bus.halted <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MEM: begin
          state        <= S_ADDR;
          bus.rom_addr <= pc;
        end
        S_HALT: ;
        default: state <= S_ADDR;
      endcase
    end
  end

endmodule
